level_key_ctrl: RTL and testbench



---
 rtl/level_key_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_level_key_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/level_key_ctrl.sv
// Key conditioner for the brightness stage: synchronises and debounces two
// active-low keys, then turns presses into single-cycle inc/dec pulses.

module level_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic pressed_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            db_q, db_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            db_q   <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    // The count only survives while the synchronised level disagrees with db_q.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == DB_LAST) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign pressed_o = ~db_q;

endmodule

module level_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic key_up_n,
    input  logic key_dn_n,
    output logic inc,
    output logic dec,
    output logic locked
);

    localparam int RT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RT_W   = $clog2(RT_MAX);
    localparam logic [RT_W-1:0] DLY_LAST = RT_W'(REPEAT_DELAY - 1);
    localparam logic [RT_W-1:0] RPT_LAST = RT_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        IDLE,
        UP_DLY,
        UP_RPT,
        DN_DLY,
        DN_RPT,
        LOCK
    } state_t;

    state_t          state_q, state_d;
    logic [RT_W-1:0] rt_q, rt_d;
    logic            inc_q, inc_d;
    logic            dec_q, dec_d;
    logic            locked_q;
    logic            up, dn;

    level_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk       (clk),
        .rst       (rst),
        .key_n_i   (key_up_n),
        .pressed_o (up)
    );

    level_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk       (clk),
        .rst       (rst),
        .key_n_i   (key_dn_n),
        .pressed_o (dn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rt_q     <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rt_q     <= rt_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            locked_q <= (state_d == LOCK);
        end
    end

    // Release of the own key wins over a press of the other key.
    always_comb begin
        state_d = state_q;
        rt_d    = rt_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        if (!en) begin
            state_d = IDLE;
            rt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rt_d = '0;
                    if (up && dn) begin
                        state_d = LOCK;
                    end else if (up) begin
                        state_d = UP_DLY;
                        inc_d   = 1'b1;
                    end else if (dn) begin
                        state_d = DN_DLY;
                        dec_d   = 1'b1;
                    end
                end
                UP_DLY, UP_RPT: begin
                    if (!up) begin
                        state_d = IDLE;
                        rt_d    = '0;
                    end else if (dn) begin
                        state_d = LOCK;
                        rt_d    = '0;
                    end else if (rt_q == ((state_q == UP_DLY) ? DLY_LAST : RPT_LAST)) begin
                        state_d = UP_RPT;
                        inc_d   = 1'b1;
                        rt_d    = '0;
                    end else begin
                        rt_d = rt_q + 1'b1;
                    end
                end
                DN_DLY, DN_RPT: begin
                    if (!dn) begin
                        state_d = IDLE;
                        rt_d    = '0;
                    end else if (up) begin
                        state_d = LOCK;
                        rt_d    = '0;
                    end else if (rt_q == ((state_q == DN_DLY) ? DLY_LAST : RPT_LAST)) begin
                        state_d = DN_RPT;
                        dec_d   = 1'b1;
                        rt_d    = '0;
                    end else begin
                        rt_d = rt_q + 1'b1;
                    end
                end
                LOCK: begin
                    rt_d = '0;
                    if (!up && !dn) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rt_d    = '0;
                end
            endcase
        end
    end

    assign inc    = inc_q;
    assign dec    = dec_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_level_key_ctrl.sv
// Scoreboard bench for level_key_ctrl: each press/release schedules the pulses
// it must cause; a negedge monitor matches DUT pulses against that queue.

module tb_level_key_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    // A raw change driven after edge m is first sampled at m+1 and acted on at m+7.
    localparam int LAT = DB + 3;

    localparam logic [1:0] K_INC = 2'b10;
    localparam logic [1:0] K_DEC = 2'b01;

    typedef struct {
        int         at;
        logic [1:0] kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic key_up_n = 1'b1;
    logic key_dn_n = 1'b1;
    logic inc, dec, locked;

    int   edge_n = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    level_key_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .key_up_n (key_up_n),
        .key_dn_n (key_dn_n),
        .inc      (inc),
        .dec      (dec),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [1:0] kind);
        exp_t e;
        e.at   = at;
        e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Missed pulses are retired first, then any observed pulse is matched.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].at < edge_n) begin
            check("missed_pulse", 32'(edge_n), 32'(sb[0].at));
            void'(sb.pop_front());
        end
        if (inc || dec) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({inc, dec}), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_edge", 32'(edge_n), 32'(e.at));
                check("pulse_kind", 32'({inc, dec}), 32'(e.kind));
            end
        end
    end

    initial begin
        int m;
        int t;
        int e;

        // Reset and idle
        tick(3);
        check("rst_inc", 32'(inc), 32'd0);
        check("rst_dec", 32'(dec), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst = 1'b0;
        tick(50);
        check("idle_locked", 32'(locked), 32'd0);
        check("idle_flush", 32'(sb.size()), 32'd0);

        // Single press
        m = edge_n;
        key_up_n = 1'b0;
        expect_pulse(m + LAT, K_INC);
        tick(8);
        key_up_n = 1'b1;
        tick(15);
        check("single_flush", 32'(sb.size()), 32'd0);

        // Bounce rejection, then a clean hold
        repeat (5) begin
            key_dn_n = 1'b0;
            tick(2);
            key_dn_n = 1'b1;
            tick(2);
        end
        m = edge_n;
        key_dn_n = 1'b0;
        expect_pulse(m + LAT, K_DEC);
        tick(8);
        key_dn_n = 1'b1;
        tick(15);
        check("bounce_flush", 32'(sb.size()), 32'd0);

        // Auto-repeat: held 30 cycles, debounced release ends it at T+30
        m = edge_n;
        t = m + LAT;
        key_up_n = 1'b0;
        expect_pulse(t, K_INC);
        for (int i = 0; i < 7; i++) expect_pulse(t + RD + RR * i, K_INC);
        tick(30);
        key_up_n = 1'b1;
        tick(20);
        check("repeat_flush", 32'(sb.size()), 32'd0);

        // Lockout from UP_RPT
        m = edge_n;
        t = m + LAT;
        key_up_n = 1'b0;
        expect_pulse(t, K_INC);
        expect_pulse(t + RD, K_INC);
        expect_pulse(t + RD + RR, K_INC);
        expect_pulse(t + RD + 2 * RR, K_INC);
        tick(18);
        check("pre_lock", 32'(locked), 32'd0);
        key_dn_n = 1'b0;
        tick(9);
        check("lock_set", 32'(locked), 32'd1);
        key_dn_n = 1'b1;
        tick(12);
        check("lock_hold_up", 32'(locked), 32'd1);
        key_up_n = 1'b1;
        tick(10);
        check("lock_exit", 32'(locked), 32'd0);
        check("lock_flush", 32'(sb.size()), 32'd0);
        m = edge_n;
        key_up_n = 1'b0;
        expect_pulse(m + LAT, K_INC);
        tick(8);
        key_up_n = 1'b1;
        tick(15);
        check("fresh_flush", 32'(sb.size()), 32'd0);

        // Reset during UP_DLY with the key still held
        m = edge_n;
        key_up_n = 1'b0;
        expect_pulse(m + LAT, K_INC);
        tick(11);
        rst = 1'b1;
        tick(1);
        check("midrst_locked", 32'(locked), 32'd0);
        rst = 1'b0;
        t = edge_n + LAT;
        expect_pulse(t, K_INC);
        expect_pulse(t + RD, K_INC);
        expect_pulse(t + RD + RR, K_INC);

        // Enable dropped in UP_RPT, then raised with the key held
        tick(t + RD + RR + 1 - edge_n);
        en = 1'b0;
        tick(20);
        check("en_low_flush", 32'(sb.size()), 32'd0);
        e = edge_n;
        en = 1'b1;
        expect_pulse(e + 1, K_INC);
        expect_pulse(e + 1 + RD, K_INC);
        expect_pulse(e + 1 + RD + RR, K_INC);
        expect_pulse(e + 1 + RD + 2 * RR, K_INC);
        tick(12);
        key_up_n = 1'b1;
        tick(20);
        check("en_flush", 32'(sb.size()), 32'd0);
        check("end_locked", 32'(locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
